// File: rtl/cond_unit_pkg.sv
// Shared definitions for the conditional-execution stage: ARM condition codes
// and the bit positions of N, Z, C and V inside the flag register.
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/cond_unit_check.sv
// Purely combinational condition evaluator: maps the 4-bit condition field and
// the registered NZCV flags to a single pass/fail bit.
module cond_check
    import cond_unit_pkg::*;
#(
    parameter int NV_EXECUTES = 0
) (
    input  logic [3:0] Cond,
    input  nzcv_t      Flags,
    output logic       CondEx
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = (NV_EXECUTES != 0);
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and
// gates the control FSM's raw strobes into the committed datapath enables.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int NV_EXECUTES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    nzcv_t      flags_p1;
    logic       cond_ex_p1;
    logic [1:0] flag_write;

    cond_check #(
        .NV_EXECUTES(NV_EXECUTES)
    ) u_cond_check (
        .Cond  (Cond),
        .Flags (flags_p1),
        .CondEx(CondEx)
    );

    // Flag updates are gated by this cycle's condition, evaluated on the old flags.
    assign flag_write = FlagW & {2{CondEx}};

    // ---- stage p1: architectural flags and delayed condition pass ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_p1 <= '0;
        end else begin
            if (flag_write[1]) begin
                flags_p1[FLAG_N] <= ALUFlags[FLAG_N];
                flags_p1[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (flag_write[0]) begin
                flags_p1[FLAG_C] <= ALUFlags[FLAG_C];
                flags_p1[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // A multi-state instruction commits on the condition seen before its own flag write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_p1 <= 1'b0;
        end else begin
            cond_ex_p1 <= CondEx;
        end
    end

    assign PCWrite  = NextPC | (PCS & cond_ex_p1);
    assign RegWrite = RegW & cond_ex_p1;
    assign MemWrite = MemW & cond_ex_p1;
    assign Flags    = flags_p1;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage of the multicycle ARM controller. Sits directly downstream of the main control FSM.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it.
- Gates the FSM's raw strobes (NextPC, Branch/PCS, RegW, MemW) into the committed datapath enables PCWrite, RegWrite and MemWrite.
- Contains the one-cycle-delayed condition-pass register, so a multi-state instruction commits using the condition evaluated before its own flag update.

Parameters:
- NV_EXECUTES, 0, when 1 the cond code 4'b1111 passes (treated like AL); when 0 it never passes.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- Cond  input  4  condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
- FlagW  input  2  flag-write request from the decoder: [1] = N,Z; [0] = C,V.
- PCS  input  1  PC-source strobe (Branch or write-to-R15) from the decoder/FSM.
- NextPC  input  1  unconditional PC update (fetch) from the FSM.
- RegW  input  1  raw register-write strobe from the FSM.
- MemW  input  1  raw memory-write strobe from the FSM.
- PCWrite  output  1  committed PC enable.
- RegWrite  output  1  committed register-file write enable.
- MemWrite  output  1  committed data-memory write enable.
- CondEx  output  1  combinational condition pass for the current cycle.
- Flags  output  4  current registered {N,Z,C,V}, for debug and the bench.

Behaviour:
- Reset (async, active-high): Flags=4'b0000, CondExDelayed=0. PCWrite follows NextPC; RegWrite=0 and MemWrite=0 immediately.
- Condition decode (combinational on registered Flags):
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: NV_EXECUTES.
- FlagWrite[1:0] = FlagW & {2{CondEx}}, using the undelayed CondEx.
- On posedge clk:
  - if FlagWrite[1], {N,Z} <= ALUFlags[3:2];
  - if FlagWrite[0], {C,V} <= ALUFlags[1:0];
  - the two halves are independent.
- CondExDelayed <= CondEx on every posedge clk, unconditionally. Latency is 1 cycle.
- Outputs (combinational):
  - PCWrite = NextPC | (PCS & CondExDelayed).
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
- Simultaneous events:
  - A flag write and a condition evaluation in the same cycle: CondEx uses the old flags; new flags are visible from the next cycle.
  - NextPC=1 forces PCWrite=1 regardless of condition.
- Reset mid-instruction: in-flight strobes are suppressed immediately because CondExDelayed is cleared; flags are lost.
- No X propagation: every Cond value maps to a defined result.

Decomposition:
- Shared package: localparams for the 16 condition codes (COND_EQ..COND_NV) and the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One natural sub-module, cond_check: purely combinational, (Cond, Flags) -> CondEx.
- The flag register, delay register and gating stay in cond_unit.

Test Plan:
- Reset, then Cond=1110, RegW=1 on the next cycle -> RegWrite=1 one cycle after CondEx=1. Flags=0000 throughout.
- FlagW=11, ALUFlags=0100, Cond=1110 -> Flags=0100 next cycle. Then Cond=0000 (EQ), MemW=1 -> MemWrite=1. Cond=0001 (NE) -> MemWrite=0.
- FlagW=01, ALUFlags=1111 with Flags=0100 -> Flags=0111 (N,Z unchanged). Then Cond=1010 (GE) -> CondEx=0; Cond=1011 (LT) -> CondEx=1.
- Cond=0000 with Z=0, FlagW=11, ALUFlags=0100 -> flags unchanged (FlagWrite gated), PCS=1 -> PCWrite=0. NextPC=1 -> PCWrite=1.
- Sweep all 16 Cond codes x 16 flag values -> CondEx matches the table. Cond=1111 gives 0 with NV_EXECUTES=0 and 1 with NV_EXECUTES=1.
- Assert reset while CondExDelayed=1 and RegW=1 -> RegWrite drops to 0 in the same cycle, Flags=0000.
